// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: FSM states,
// verdict codes and the expected-store table entry.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_ADR     = 3'd1,
    FC_DATA    = 3'd2,
    FC_EXTRA   = 3'd3,
    FC_MISSING = 3'd4,
    FC_TIMEOUT = 3'd5
  } fail_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/store_exp_table.sv
// Expected-store register file: one write port,
// one combinational read port, contents survive reset.
module store_exp_table
  import store_monitor_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  entry_t        wentry_i,
  input  logic [IW-1:0] ridx_i,
  output entry_t        rentry_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wentry_i;
  end

  assign rentry_o = mem_q[ridx_i];

endmodule

// File: rtl/store_monitor.sv
// Observes processor stores, checks them in order against
// the expected table and reports a sticky pass/fail verdict.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT     = 4096,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [31:0]   exp_adr,
  input  logic [31:0]   exp_data,
  input  logic [3:0]    exp_be,
  input  logic [CW-1:0] exp_count,
  input  logic          MemWrite,
  input  logic [31:0]   DataAdr,
  input  logic [31:0]   WriteData,
  input  logic [3:0]    byteEnable,
  input  logic [31:0]   PC,
  output logic          done,
  output logic          pass,
  output logic [2:0]    fail_code,
  output logic [CW-1:0] store_cnt,
  output logic [31:0]   cycle_cnt
);

  localparam int HW = $clog2(HALT_CYCLES) + 1;

  state_e        state_q, state_d;
  fail_e         code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lim_q, lim_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [31:0]   pc_q;
  entry_t        ent;
  entry_t        wentry;
  logic          tbl_we;
  logic          halt;
  logic          adr_bad;
  logic          data_bad;

  assign tbl_we = exp_we && (state_q == ST_IDLE);
  assign wentry = '{adr: exp_adr, data: exp_data, be: exp_be};

  store_exp_table #(.DEPTH(DEPTH)) u_table (
    .clk      (clk),
    .we_i     (tbl_we),
    .widx_i   (exp_idx),
    .wentry_i (wentry),
    .ridx_i   (cnt_q[IW-1:0]),
    .rentry_o (ent)
  );

  // After a clean address/lane match only the enabled lanes are compared
  assign adr_bad  = (DataAdr != ent.adr) || (byteEnable != ent.be);
  assign data_bad = |((WriteData ^ ent.data) & be_mask(ent.be));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    cyc_d   = cyc_q;
    hcnt_d  = hcnt_q;
    halt    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          lim_d   = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;
          cnt_d   = '0;
          cyc_d   = '0;
          hcnt_d  = '0;
        end
      end
      ST_RUN: begin
        cyc_d  = cyc_q + 32'd1;
        hcnt_d = (PC == pc_q) ? hcnt_q + HW'(1) : '0;
        halt   = (hcnt_d == HW'(HALT_CYCLES - 1));
        if (MemWrite && (cnt_q == lim_q)) begin
          state_d = ST_FAIL;
          code_d  = FC_EXTRA;
        end else if (MemWrite && adr_bad) begin
          state_d = ST_FAIL;
          code_d  = FC_ADR;
        end else if (MemWrite && data_bad) begin
          state_d = ST_FAIL;
          code_d  = FC_DATA;
        end else begin
          if (MemWrite) cnt_d = cnt_q + CW'(1);
          if (halt) begin
            if (cnt_d != lim_q) begin
              state_d = ST_FAIL;
              code_d  = FC_MISSING;
            end else begin
              state_d = ST_PASS;
            end
          end else if (cyc_q == 32'(TIMEOUT - 1)) begin
            state_d = ST_FAIL;
            code_d  = FC_TIMEOUT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= FC_NONE;
      cnt_q   <= '0;
      lim_q   <= '0;
      cyc_q   <= '0;
      hcnt_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      cyc_q   <= cyc_d;
      hcnt_q  <= hcnt_d;
      pc_q    <= PC;
    end
  end

  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass      = (state_q == ST_PASS);
  assign fail_code = code_q;
  assign store_cnt = cnt_q;
  assign cycle_cnt = cyc_q;

endmodule
